// File: rtl/dense_input_packer_if.sv
// Beat stream into the dense-core input packer: valid/ready with an end-of-frame marker.
interface dense_input_packer_if #(
  parameter int unsigned W          = 16,
  parameter int unsigned BEAT_WORDS = 4
);
  logic                    s_valid;
  logic                    s_ready;
  logic [BEAT_WORDS*W-1:0] s_data;
  logic                    s_last;

  modport master (output s_valid, s_data, s_last, input s_ready);
  modport slave  (input s_valid, s_data, s_last, output s_ready);
endinterface

// File: rtl/dense_input_packer.sv
// Assembles BEAT_WORDS-wide beats into a ping-pong pair of N_WORDS frame banks and
// hands each full bank to the dense core, holding it stable until core_done.
module dense_input_packer #(
  parameter int unsigned W          = 16,
  parameter int unsigned N_WORDS    = 64,
  parameter int unsigned BEAT_WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  dense_input_packer_if.slave  s_if,
  output logic                 core_start,
  output logic                 core_vld,
  output logic [N_WORDS*W-1:0] core_data,
  input  logic                 core_idle,
  input  logic                 core_done,
  output logic                 err_short,
  output logic                 err_long,
  output logic [15:0]          frame_count
);
  localparam int unsigned BEATS     = N_WORDS / BEAT_WORDS;
  localparam int unsigned BEAT_BITS = BEAT_WORDS * W;
  localparam int unsigned CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} issue_state_e;

  issue_state_e         state, state_nxt;
  logic [N_WORDS*W-1:0] bank [2];
  logic [1:0]           full;
  logic                 wr_sel, rd_sel;
  logic [CNT_W-1:0]     beat_cnt;
  logic                 dropping;
  logic                 accept, wr_en, last_beat, frame_end, free_bank;

  always_comb begin
    s_if.s_ready = !rst && (!full[wr_sel] || dropping);
    accept       = s_if.s_valid && s_if.s_ready;
    wr_en        = accept && !dropping;
    last_beat    = (beat_cnt == LAST_BEAT);
    frame_end    = last_beat || s_if.s_last;
    free_bank    = (state == S_WAIT) && core_done;
    core_data    = bank[rd_sel];
  end

  // The write bank is never full and the read bank always is while in WAIT,
  // so fill and free always touch different banks.
  always_ff @(posedge clk) begin
    if (rst) begin
      bank[0] <= '0;
      bank[1] <= '0;
    end else begin
      if (free_bank)
        bank[rd_sel] <= '0;
      if (wr_en)
        for (int unsigned k = 0; k < BEATS; k++)
          if (beat_cnt == CNT_W'(k))
            bank[wr_sel][k*BEAT_BITS +: BEAT_BITS] <= s_if.s_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full        <= '0;
      wr_sel      <= 1'b0;
      rd_sel      <= 1'b0;
      beat_cnt    <= '0;
      dropping    <= 1'b0;
      err_short   <= 1'b0;
      err_long    <= 1'b0;
      frame_count <= '0;
    end else begin
      err_short <= wr_en && s_if.s_last && !last_beat;
      err_long  <= wr_en && last_beat && !s_if.s_last;
      if (wr_en) begin
        if (frame_end) begin
          full[wr_sel] <= 1'b1;
          wr_sel       <= ~wr_sel;
          beat_cnt     <= '0;
          dropping     <= !s_if.s_last;
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
        end
      end else if (accept && s_if.s_last) begin
        dropping <= 1'b0;
      end
      if (free_bank) begin
        full[rd_sel] <= 1'b0;
        rd_sel       <= ~rd_sel;
        frame_count  <= frame_count + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (full[rd_sel] && core_idle) state_nxt = S_START;
      S_START: state_nxt = S_WAIT;
      S_WAIT:  if (core_done) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    core_start = (state == S_START);
    core_vld   = (state == S_START) || (state == S_WAIT);
  end
endmodule
